// File: rtl/picture_result_writer_if.sv
// Lane result handshake and memory write port of the picture result writer.
// master: the writer itself; slave: the unit array / memory side.
interface picture_result_writer_if #(
    parameter int N_UNITS = 16,
    parameter int DATA_W  = 32
);
    logic [N_UNITS-1:0] unit_valid;
    logic [DATA_W-1:0]  unit_data [N_UNITS-1:0];
    logic [N_UNITS-1:0] unit_ready;
    logic               mem_wr_req;
    logic [31:0]        mem_wr_addr;
    logic [DATA_W-1:0]  mem_wr_data;
    logic               mem_wr_ack;

    modport master (
        input  unit_valid, unit_data, mem_wr_ack,
        output unit_ready, mem_wr_req, mem_wr_addr, mem_wr_data
    );

    modport slave (
        output unit_valid, unit_data, mem_wr_ack,
        input  unit_ready, mem_wr_req, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/picture_result_writer.sv
// Collects one result per targeted lane, then drains them as addressed memory writes.
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_COLLECT | readying target lanes not yet captured
//   S_WRITE   | one write request per pending lane, lowest lane first
//   S_DONE    | one-cycle done pulse
module picture_result_writer #(
    parameter int N_UNITS = 16,
    parameter int DATA_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [31:0]         out_base,
    input  logic [15:0]         total_count,
    input  logic [N_UNITS-1:0]  active_units,
    picture_result_writer_if.master bus,
    output logic                busy,
    output logic                done
);
    localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

    state_t             state;
    logic [N_UNITS-1:0] mask;
    logic [N_UNITS-1:0] target;
    logic [N_UNITS-1:0] pending;
    logic [DATA_W-1:0]  buffer [N_UNITS-1:0];
    logic [31:0]        wr_ptr;
    logic [15:0]        remaining;

    logic [N_UNITS-1:0] ready_q;
    logic               req_q;
    logic [31:0]        addr_q;
    logic [DATA_W-1:0]  data_q;

    logic [N_UNITS-1:0] capture;
    logic [N_UNITS-1:0] pend_after;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   nxt_idx;
    logic [15:0]        remaining_dec;

    // Lowest min(popcount(m), rem) set bits of m.
    function automatic logic [N_UNITS-1:0] pick_target(input logic [N_UNITS-1:0] m,
                                                       input logic [15:0] rem);
        logic [N_UNITS-1:0] pick;
        logic [16:0]        cnt;
        pick = '0;
        cnt  = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (m[i] && (cnt < {1'b0, rem})) begin
                pick[i] = 1'b1;
                cnt     = cnt + 17'd1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_UNITS-1:0] p);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (p[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        capture       = bus.unit_valid & ready_q;
        pend_after    = pending & (pending - N_UNITS'(1));
        sel_idx       = lowest_idx(pending);
        nxt_idx       = lowest_idx(pend_after);
        remaining_dec = remaining - 16'd1;
    end

    assign bus.unit_ready  = ready_q;
    assign bus.mem_wr_req  = req_q;
    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mask      <= '0;
            target    <= '0;
            pending   <= '0;
            wr_ptr    <= '0;
            remaining <= '0;
            ready_q   <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < N_UNITS; i++) buffer[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask      <= active_units;
                        wr_ptr    <= out_base;
                        remaining <= total_count;
                        pending   <= '0;
                        if (active_units == '0 || total_count == 16'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            target  <= pick_target(active_units, total_count);
                            ready_q <= pick_target(active_units, total_count);
                            busy    <= 1'b1;
                            state   <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (pending == target) begin
                        state  <= S_WRITE;
                        req_q  <= 1'b1;
                        addr_q <= wr_ptr;
                        data_q <= buffer[sel_idx];
                    end else begin
                        for (int i = 0; i < N_UNITS; i++) begin
                            if (capture[i]) buffer[i] <= bus.unit_data[i];
                        end
                        pending <= pending | capture;
                        ready_q <= ready_q & ~capture;
                    end
                end
                S_WRITE: begin
                    // req is high for the whole of WRITE, so ack alone qualifies a transfer
                    if (bus.mem_wr_ack) begin
                        pending   <= pend_after;
                        wr_ptr    <= wr_ptr + 32'd1;
                        remaining <= remaining_dec;
                        if (pend_after != '0) begin
                            addr_q <= wr_ptr + 32'd1;
                            data_q <= buffer[nxt_idx];
                        end else begin
                            req_q <= 1'b0;
                            if (remaining_dec == 16'd0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                target  <= pick_target(mask, remaining_dec);
                                ready_q <= pick_target(mask, remaining_dec);
                                state   <= S_COLLECT;
                            end
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_picture_result_writer.sv
// Randomized bench for picture_result_writer with a batch-level reference model.
module tb_picture_result_writer;
    localparam int NU = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   out_base = '0;
    logic [15:0]   total_count = '0;
    logic [NU-1:0] active_units = '0;
    logic          busy, done;

    picture_result_writer_if #(.N_UNITS(NU), .DATA_W(DW)) bus ();

    picture_result_writer #(.N_UNITS(NU), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .out_base     (out_base),
        .total_count  (total_count),
        .active_units (active_units),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [31:0]   exp_addr [$];
    logic [DW-1:0] exp_data [$];
    int            batch_sz [$];
    logic [NU-1:0] batch_tgt [$];
    logic [DW-1:0] lane_vals [NU][32];
    int            lane_idx [NU];

    task automatic build_model(input logic [31:0] base, input int count, input logic [NU-1:0] mask);
        int lane_cnt [NU];
        int rem, pop, k, taken, written;
        logic [NU-1:0] tgt;
        exp_addr.delete(); exp_data.delete(); batch_sz.delete(); batch_tgt.delete();
        for (int i = 0; i < NU; i++) lane_cnt[i] = 0;
        pop = 0;
        for (int i = 0; i < NU; i++) if (mask[i]) pop++;
        rem = count;
        written = 0;
        while (pop > 0 && rem > 0) begin
            k = (pop < rem) ? pop : rem;
            tgt = '0;
            taken = 0;
            for (int i = 0; i < NU; i++) begin
                if (mask[i] && taken < k) begin
                    tgt[i] = 1'b1;
                    taken++;
                    exp_addr.push_back(base + 32'(written));
                    exp_data.push_back(lane_vals[i][lane_cnt[i]]);
                    lane_cnt[i]++;
                    written++;
                end
            end
            batch_sz.push_back(k);
            batch_tgt.push_back(tgt);
            rem -= k;
        end
    endtask

    // vmode: 0 random valid, 1 always valid, 2 always valid except lane 2 late by 5 cycles
    // ack_mode: 0 ack always high, 1 random, 2 ack after 3 stall cycles per request
    task automatic run_job(input logic [31:0] base, input int count, input logic [NU-1:0] mask,
                           input int ack_mode, input int vmode, input bit poke);
        int b_idx, left, cum, sum_idx, wait_cnt, last_ack_cyc;
        bit seen_done, prev_req, prev_acked, expect_req;
        logic [31:0] prev_addr;
        logic [DW-1:0] prev_data;
        logic [NU-1:0] cur_tgt;
        logic v, a;
        for (int i = 0; i < NU; i++) begin
            lane_idx[i] = 0;
            for (int j = 0; j < 32; j++) lane_vals[i][j] = $urandom;
        end
        build_model(base, count, mask);
        b_idx = 0;
        left = (batch_sz.size() > 0) ? batch_sz[0] : 0;
        cum = left;
        wait_cnt = 0;
        last_ack_cyc = -1;
        seen_done = 0; prev_req = 0; prev_acked = 0; expect_req = 0;
        prev_addr = '0; prev_data = '0;

        @(negedge clk);
        start = 1'b1; out_base = base; total_count = 16'(count); active_units = mask;
        @(negedge clk);
        start = 1'b0; out_base = $urandom; active_units = NU'($urandom);

        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done) begin
                seen_done = 1;
                check_val("busy_at_done", busy, 0);
                check_val("req_at_done", bus.mem_wr_req, 0);
                check_val("writes_left", exp_addr.size(), 0);
                if (batch_sz.size() == 0) check_val("empty_done_cyc", cyc, 0);
                else check_val("done_after_ack", cyc, last_ack_cyc + 1);
            end else begin
                cur_tgt = (batch_tgt.size() > 0) ? batch_tgt[b_idx] : '0;
                sum_idx = 0;
                for (int i = 0; i < NU; i++) sum_idx += lane_idx[i];
                check_val("busy", busy, 1);
                check_val("ready_out_of_target", bus.unit_ready & ~cur_tgt, 0);
                if (bus.mem_wr_req) begin
                    check_val("ready_in_write", bus.unit_ready, 0);
                    check_val("req_before_capture", sum_idx, cum);
                end
                if (prev_req && !prev_acked) begin
                    check_val("req_hold", bus.mem_wr_req, 1);
                    check_val("addr_hold", bus.mem_wr_addr, prev_addr);
                    check_val("data_hold", bus.mem_wr_data, prev_data);
                end
                if (expect_req) check_val("back_to_back", bus.mem_wr_req, 1);
                expect_req = 0;

                start = poke && cyc == 3;
                if (poke && cyc == 3) begin
                    out_base = $urandom; total_count = 16'd9; active_units = '1;
                end
                for (int i = 0; i < NU; i++) begin
                    case (vmode)
                        0: v = ($urandom_range(0, 3) != 0);
                        2: v = !(i == 2 && cyc < 5);
                        default: v = 1'b1;
                    endcase
                    bus.unit_valid[i] = v;
                    bus.unit_data[i] = lane_vals[i][lane_idx[i]];
                    if (v && bus.unit_ready[i]) lane_idx[i]++;
                end
                case (ack_mode)
                    0: a = 1'b1;
                    1: a = ($urandom_range(0, 2) != 0);
                    default: begin
                        a = 1'b0;
                        if (bus.mem_wr_req) begin
                            if (wait_cnt == 3) begin a = 1'b1; wait_cnt = 0; end
                            else wait_cnt++;
                        end
                    end
                endcase
                bus.mem_wr_ack = a;
                if (a && bus.mem_wr_req) begin
                    if (exp_addr.size() == 0) begin
                        check_val("extra_write", 1, 0);
                    end else begin
                        check_val("wr_addr", bus.mem_wr_addr, exp_addr.pop_front());
                        check_val("wr_data", bus.mem_wr_data, exp_data.pop_front());
                        last_ack_cyc = cyc;
                        left--;
                        if (left > 0) expect_req = 1;
                        else if (b_idx + 1 < batch_sz.size()) begin
                            b_idx++;
                            left = batch_sz[b_idx];
                            cum += left;
                        end
                    end
                end
                prev_req = bus.mem_wr_req;
                prev_acked = a && bus.mem_wr_req;
                prev_addr = bus.mem_wr_addr;
                prev_data = bus.mem_wr_data;
            end
        end
        if (!seen_done) check_val("timeout", 1, 0);
        start = 1'b0;
        bus.unit_valid = '0;
        bus.mem_wr_ack = 1'b0;
        @(negedge clk);
        check_val("done_one_cycle", done, 0);
        check_val("idle_busy", busy, 0);
    endtask

    task automatic reset_mid_write();
        int acks = 0;
        @(negedge clk);
        start = 1'b1; out_base = 32'h200; total_count = 16'd4; active_units = 4'b1111;
        bus.unit_valid = '1;
        bus.mem_wr_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && acks == 0; c++) begin
            if (bus.mem_wr_req) acks++;
            @(negedge clk);
        end
        check_val("reset_setup_req", bus.mem_wr_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.unit_valid = '0;
        check_val("rst_ready", bus.unit_ready, 0);
        check_val("rst_req", bus.mem_wr_req, 0);
        check_val("rst_addr", bus.mem_wr_addr, 0);
        check_val("rst_data", bus.mem_wr_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("rst_no_done", done, 0);
            check_val("rst_no_req", bus.mem_wr_req, 0);
        end
        bus.mem_wr_ack = 1'b0;
    endtask

    initial begin
        bus.unit_valid = '0;
        bus.mem_wr_ack = 1'b0;
        for (int i = 0; i < NU; i++) bus.unit_data[i] = '0;
        repeat (2) @(negedge clk);
        check_val("reset_ready", bus.unit_ready, 0);
        check_val("reset_req", bus.mem_wr_req, 0);
        check_val("reset_addr", bus.mem_wr_addr, 0);
        check_val("reset_data", bus.mem_wr_data, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        rst_n = 1'b1;

        run_job(32'h100, 4, 4'b1111, 0, 1, 0);
        run_job(32'h100, 5, 4'b1010, 0, 1, 0);
        run_job(32'h100, 4, 4'b1111, 2, 2, 0);
        run_job(32'h40, 0, 4'b1111, 0, 1, 0);
        run_job(32'h40, 3, 4'b0000, 0, 1, 0);
        run_job(32'h300, 6, 4'b0111, 1, 0, 1);
        reset_mid_write();
        run_job(32'h500, 4, 4'b1111, 0, 1, 0);
        run_job(32'hFFFF_FFFF, 2, 4'b0011, 0, 1, 0);
        for (int j = 0; j < 8; j++) begin
            run_job($urandom, $urandom_range(1, 12), NU'($urandom_range(1, 15)),
                    $urandom_range(0, 2), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/picture_result_writer.md
# picture_result_writer

Write-side counterpart to the picture address generator: collects one result per active compute unit, then drains the results to picture memory as a serial stream of addressed write requests. It sits between the unit array outputs and the memory write port. It paces the units with per-unit ready signals and advances an output pointer until a programmed number of output pixels has been written.

## Interface
Parameters:
- N_UNITS, 16, number of compute units (lanes)
- DATA_W, 32, result word width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse; latches configuration, ignored unless IDLE
- out_base  in  32  first output address
- total_count  in  16  number of output words to write for this job
- active_units  in  N_UNITS  lane enable mask
- unit_valid  in  N_UNITS  lane i has a result on unit_data[i]
- unit_data  in  DATA_W x N_UNITS (unpacked [N_UNITS-1:0])  lane results
- unit_ready  out  N_UNITS  lane i result will be captured this cycle if valid
- mem_wr_req  out  1  write request
- mem_wr_addr  out  32  write address, stable while req high
- mem_wr_data  out  DATA_W  write data, stable while req high
- mem_wr_ack  in  1  write accepted this cycle
- busy  out  1  job in progress (COLLECT or WRITE)
- done  out  1  one-cycle pulse at job completion

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE plus start:
  - latch mask, wr_ptr=out_base, remaining=total_count; clear pending.
  - If mask==0 or total_count==0, go to DONE. Otherwise, compute target and go to COLLECT.
- Target mask, computed on entry to each COLLECT: the lowest-indexed min(popcount(mask), remaining) set bits of mask. A final partial batch uses only the lowest active lanes.
- COLLECT:
  - unit_ready[i] = target[i] & ~pending[i].
  - On valid&ready, capture unit_data[i] into buffer[i] and set pending[i].
  - Valid on lanes not in target, or already pending, is ignored.
  - When registered pending==target, go to WRITE.
- WRITE:
  - sel = lowest set bit of pending.
  - mem_wr_req=1, mem_wr_addr=wr_ptr, mem_wr_data=buffer[sel].
  - On ack: clear pending[sel], wr_ptr+=1 (32-bit wrap), remaining-=1.
  - When pending becomes empty: go to DONE if remaining==0, else go to COLLECT with a new target.
  - unit_ready=0 throughout WRITE.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. active_units and out_base changes after start have no effect.

## Timing
- Reset values: state IDLE; unit_ready=0, mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0; pending, wr_ptr, remaining all cleared.
- start sampled at edge T. State is COLLECT (or DONE) from T+1. unit_ready is valid from T+1.
- Capture happens at the edge where valid&ready. Last capture at edge E gives WRITE at edge E+1, so mem_wr_req is first high in the cycle after E+1.
- Request hold rule:
  - mem_wr_req stays high with addr/data stable until the ack edge.
  - ack may arrive in the same cycle req rises.
  - The next request is presented the cycle after the ack. Sustained throughput is 1 write/cycle under continuous ack.
  - ack while req low is ignored.
- After the final ack edge A: DONE in cycle after A (done=1, busy=0), IDLE one cycle later.
- busy=1 exactly in COLLECT and WRITE.
- Outputs are driven only from state, pending and buffers; there is no combinational path from unit_valid to mem_wr_*.
- rst_n low mid-job: at the next edge, return to reset values. Buffered results are dropped and no done is emitted.

## Test plan
- N_UNITS=4, mask=4'b1111, out_base=0x100, total_count=4, all valid at once, ack always 1:
  - writes (0x100,d0),(0x101,d1),(0x102,d2),(0x103,d3) on 4 consecutive cycles;
  - done pulses once; busy falls with done.
- mask=4'b1010, total_count=5:
  - batches of 2, 2, 1; final batch targets lane 1 only, lane 3 never ready;
  - addresses 0x100..0x104 in lane order 1,3,1,3,1.
- Lanes valid staggered (lane 2 late by 5 cycles), ack delayed 3 cycles per request:
  - no req until lane 2 captured;
  - addr/data held stable through each stall;
  - unit_ready low during WRITE.
- start with mask=0 or total_count=0: done one cycle after start, no mem_wr_req ever. A second start pulse while busy produces no restart.
- rst_n low for one cycle during WRITE after 1 of 4 acks: all outputs zero next cycle, no done. A new start re-begins writes at the new out_base.
- out_base=0xFFFFFFFF, total_count=2: addresses 0xFFFFFFFF then 0x00000000.
